hdc_dataset_sequencer: RTL and testbench
========================================

# hdc_dataset_sequencer

Dataset-level scheduler for the one-shot HDC pipeline: quantizer, encoder, class-HV generator and associative memory. It pulls labelled samples from an upstream source over a valid/ready handshake, runs each one through mapping and encoding, and routes the encoded HV either to class accumulation (training phase) or to querying (testing phase). It generates the phase-boundary strobes (training finished, binarize, testing finished) and tallies correct inferences. It sits between the sample buffer/host interface and the HDC datapath control inputs.

## Interface
- NUM_CLASSES, 26, number of valid class labels (0..NUM_CLASSES-1)
- CLASS_W, 5, label / class-select width
- CNT_W, 16, sample counter and tally width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; when low, all state, counters and outputs hold (pulses are not issued)
- go  in  1  single-cycle run start; sampled only in IDLE or DONE
- cfg_train_samples  in  CNT_W  training sample count, latched on accepted go
- cfg_test_samples  in  CNT_W  testing sample count, latched on accepted go
- sample_valid  in  1  upstream sample (features + label) available
- sample_label  in  CLASS_W  label of the offered sample
- sample_ready  out  1  sequencer accepts the sample this cycle
- start_mapping  out  1  one-cycle pulse to the quantizer
- encoding_done  in  1  encoder finished the current sample
- train_mode  out  1  high throughout the training phase, including BINARIZE
- acc_strobe  out  1  one-cycle pulse; class generator accumulates the encoded HV into class_select_bits
- class_select_bits  out  CLASS_W  latched label of the current sample
- training_dataset_finished  out  1  one-cycle pulse after the last training accumulate
- start_binarizing  out  1  one-cycle pulse, issued the cycle after training_dataset_finished
- class_gen_done  in  1  binarization complete
- start_querying  out  1  one-cycle pulse to the associative memory
- query_done  in  1  class_inference valid this cycle
- class_inference  in  CLASS_W  associative-memory result
- testing_dataset_finished  out  1  one-cycle pulse after the last query
- correct_count  out  CNT_W  number of correct inferences in the current run
- label_err  out  1  sticky; set when an accepted label is >= NUM_CLASSES, cleared on go
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level, high in DONE

## Operation
- States: IDLE, TR_FETCH, TR_ENC, TR_ACC, TR_LAST, BIN_WAIT, TS_FETCH, TS_ENC, TS_QUERY, DONE.
- IDLE/DONE + go:
  - Latch both counts, clear the counters, correct_count and label_err.
  - Next state: TR_FETCH if train count ≠ 0; else BIN_WAIT via TR_LAST strobes.
  - go in any other state is ignored.
- TR_FETCH:
  - sample_ready=1.
  - On sample_valid: latch the label into class_select_bits, pulse start_mapping on the next cycle, go to TR_ENC.
- TR_ENC:
  - Wait for encoding_done, then go to TR_ACC.
- TR_ACC:
  - Pulse acc_strobe for one cycle and increment train_idx.
  - If train_idx+1 == train count go to TR_LAST, else TR_FETCH.
- TR_LAST:
  - Pulse training_dataset_finished.
  - Next cycle: pulse start_binarizing and enter BIN_WAIT.
- BIN_WAIT:
  - Wait for class_gen_done.
  - Next state: TS_FETCH if test count ≠ 0; else DONE with a testing_dataset_finished pulse.
- TS_FETCH/TS_ENC: same handshake as training. After encoding_done, pulse start_querying and go to TS_QUERY.
- TS_QUERY:
  - On query_done, compare class_inference with the latched label; equal → correct_count+1 (saturating at all-ones).
  - Increment test_idx.
  - Last sample → pulse testing_dataset_finished and go to DONE; else TS_FETCH.
- Labels >= NUM_CLASSES:
  - The sample is still consumed and sequenced normally.
  - label_err is set, and acc_strobe is suppressed for that sample.
- Done strobes (encoding_done, class_gen_done, query_done) arriving in a state not waiting for them are ignored.

## Timing
- Reset values: every output 0, state IDLE.
- Reset asserted mid-run returns to IDLE immediately with no strobes issued.
- Handshake: transfer occurs on the cycle sample_valid & sample_ready are both high. sample_ready is combinational from state only, with no dependence on sample_valid.
- start_mapping occurs exactly 1 cycle after the transfer.
- Minimum per training sample, with encoding_done arriving the cycle after start_mapping: 4 cycles (fetch, map pulse, enc, acc).
- All output pulses are exactly one cycle wide.
- class_select_bits is stable from the cycle after the transfer until the next transfer.
- en low freezes the FSM for its duration. An input strobe arriving while en=0 is lost; the producer must hold or re-issue it.

## Configuration
- HDC_SEQ_ACC_COUNT_EN
  - Defined: comparator and correct_count tally as described.
  - Undefined: comparator and tally removed, correct_count tied to 0; the sequencing is otherwise identical.

## Structure
- Shared package hdc_pkg holds:
  - the state enum typedef
  - NUM_CLASSES
  - CLASS_W
  - CNT_W
- Sub-module hdc_seq_counter (load, clear, increment, terminal-count flag) is instantiated twice, for train_idx and test_idx.

## Test plan
- Train 3, test 2, immediate valid, all labels correct → 3 acc_strobe pulses, then training_dataset_finished and start_binarizing on consecutive cycles, 2 start_querying pulses, correct_count=2, done=1.
- Train 0, test 0, go → training_dataset_finished, start_binarizing, wait for class_gen_done, then testing_dataset_finished; no sample_ready while sample_valid=1.
- Test 4 with inferences {match, mismatch, match, mismatch} → correct_count=2; with HDC_SEQ_ACC_COUNT_EN undefined → 0.
- Label 30 in training → label_err=1, acc_strobe absent for that sample, remaining samples processed, label_err cleared on next go.
- rst pulsed during TS_QUERY → all outputs 0 next cycle, FSM in IDLE; a subsequent go runs a full dataset cleanly.
- en deasserted 5 cycles during TR_ENC while sample_valid toggles → no transfers, no pulses, state resumes unchanged.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC dataset sequencer.
//   NUM_CLASSES / CLASS_W / CNT_W : label range, label width, sample counter width
//   state_t                       : sequencer FSM states, each bound to a fixed
//                                   legacy encoding (ST_* constants)
//   label_invalid()               : true for labels outside 0..NUM_CLASSES-1
package hdc_pkg;

    localparam int unsigned NUM_CLASSES = 26;
    localparam int unsigned CLASS_W     = 5;
    localparam int unsigned CNT_W       = 16;

    localparam logic [CLASS_W-1:0] MAX_LABEL = CLASS_W'(NUM_CLASSES - 1);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_TR_FETCH = 4'd1;
    localparam logic [3:0] ST_TR_ENC   = 4'd2;
    localparam logic [3:0] ST_TR_ACC   = 4'd3;
    localparam logic [3:0] ST_TR_LAST  = 4'd4;
    localparam logic [3:0] ST_BIN_WAIT = 4'd5;
    localparam logic [3:0] ST_TS_FETCH = 4'd6;
    localparam logic [3:0] ST_TS_ENC   = 4'd7;
    localparam logic [3:0] ST_TS_QUERY = 4'd8;
    localparam logic [3:0] ST_DONE     = 4'd9;

    typedef enum logic [3:0] {
        IDLE     = ST_IDLE,
        TR_FETCH = ST_TR_FETCH,
        TR_ENC   = ST_TR_ENC,
        TR_ACC   = ST_TR_ACC,
        TR_LAST  = ST_TR_LAST,
        BIN_WAIT = ST_BIN_WAIT,
        TS_FETCH = ST_TS_FETCH,
        TS_ENC   = ST_TS_ENC,
        TS_QUERY = ST_TS_QUERY,
        DONE     = ST_DONE
    } state_t;

    function automatic logic label_invalid(input logic [CLASS_W-1:0] label);
        return label > MAX_LABEL;
    endfunction

endpackage

// File: rtl/hdc_seq_counter.sv
// Sample index counter with a latched limit and a "this is the last one" flag.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : global enable, everything holds while low
//   load       : capture load_val as the limit
//   load_val   : limit (number of samples in the phase)
//   clear      : reset the running count to zero (wins over inc)
//   inc        : advance the running count by one
//   last       : high while count+1 equals the limit, i.e. the sample being
//                completed now is the final one of the phase
module hdc_seq_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clear,
    input  logic         inc,
    output logic         last
);

    logic [W-1:0] count;
    logic [W-1:0] limit;
    logic [W-1:0] count_plus1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            limit <= '0;
        end else if (en) begin
            if (load)
                limit <= load_val;
            if (clear)
                count <= '0;
            else if (inc)
                count <= count_plus1;
        end
    end

    assign count_plus1 = count + W'(1);
    assign last        = (count_plus1 == limit);

endmodule

// File: rtl/hdc_dataset_sequencer.sv
// Dataset-level scheduler for the one-shot HDC pipeline. Pulls labelled
// samples over valid/ready, sequences mapping/encoding, routes each encoded HV
// to class accumulation (training) or to the associative memory (testing),
// issues the phase-boundary strobes and tallies correct inferences.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   en                         global enable; low freezes state and masks pulses
//   go                         run start, honoured only in IDLE / DONE
//   cfg_train_samples/_test_   sample counts, latched on an accepted go
//   sample_valid/_label/_ready upstream sample handshake
//   start_mapping              pulse one cycle after each transfer
//   encoding_done              encoder finished current sample
//   train_mode                 training phase (incl. binarization wait)
//   acc_strobe                 accumulate pulse (suppressed for bad labels)
//   class_select_bits          label of the current sample
//   training_dataset_finished  pulse after last accumulate
//   start_binarizing           pulse the cycle after training_dataset_finished
//   class_gen_done             binarization complete
//   start_querying             pulse to the associative memory
//   query_done/class_inference AM result handshake
//   testing_dataset_finished   pulse on entering DONE
//   correct_count              correct inferences in this run
//   label_err                  sticky out-of-range label flag, cleared on go
//   busy / done                activity / completion levels
//
// Build option: HDC_SEQ_ACC_COUNT_EN enables the inference comparator and the
// correct_count tally; without it correct_count is tied to zero.
module hdc_dataset_sequencer
    import hdc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               go,
    input  logic [CNT_W-1:0]   cfg_train_samples,
    input  logic [CNT_W-1:0]   cfg_test_samples,
    input  logic               sample_valid,
    input  logic [CLASS_W-1:0] sample_label,
    output logic               sample_ready,
    output logic               start_mapping,
    input  logic               encoding_done,
    output logic               train_mode,
    output logic               acc_strobe,
    output logic [CLASS_W-1:0] class_select_bits,
    output logic               training_dataset_finished,
    output logic               start_binarizing,
    input  logic               class_gen_done,
    output logic               start_querying,
    input  logic               query_done,
    input  logic [CLASS_W-1:0] class_inference,
    output logic               testing_dataset_finished,
    output logic [CNT_W-1:0]   correct_count,
    output logic               label_err,
    output logic               busy,
    output logic               done
);

    state_t state, state_nxt;

    logic go_acc;
    logic xfer;
    logic train_last;
    logic test_last;
    logic test_empty;
    logic cur_bad;

    // Delayed pulses are held in these flags and only shown while en is high,
    // so a freeze defers the pulse instead of stretching or dropping it.
    logic map_pend;
    logic bin_pend;
    logic qry_pend;
    logic tsf_pend;

    assign go_acc = go && ((state == IDLE) || (state == DONE));
    assign xfer   = sample_ready && sample_valid;

    hdc_seq_counter #(.W(CNT_W)) u_train_idx (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (go_acc),
        .load_val (cfg_train_samples),
        .clear    (go_acc),
        .inc      (state == TR_ACC),
        .last     (train_last)
    );

    hdc_seq_counter #(.W(CNT_W)) u_test_idx (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (go_acc),
        .load_val (cfg_test_samples),
        .clear    (go_acc),
        .inc      ((state == TS_QUERY) && query_done),
        .last     (test_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE:
                if (go)
                    state_nxt = (cfg_train_samples != '0) ? TR_FETCH : TR_LAST;
            TR_FETCH: if (sample_valid)  state_nxt = TR_ENC;
            TR_ENC:   if (encoding_done) state_nxt = TR_ACC;
            TR_ACC:   state_nxt = train_last ? TR_LAST : TR_FETCH;
            TR_LAST:  state_nxt = BIN_WAIT;
            BIN_WAIT: if (class_gen_done) state_nxt = test_empty ? DONE : TS_FETCH;
            TS_FETCH: if (sample_valid)  state_nxt = TS_ENC;
            TS_ENC:   if (encoding_done) state_nxt = TS_QUERY;
            TS_QUERY: if (query_done)    state_nxt = test_last ? DONE : TS_FETCH;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            map_pend          <= 1'b0;
            bin_pend          <= 1'b0;
            qry_pend          <= 1'b0;
            tsf_pend          <= 1'b0;
            test_empty        <= 1'b0;
            cur_bad           <= 1'b0;
            label_err         <= 1'b0;
            class_select_bits <= '0;
        end else if (en) begin
            state    <= state_nxt;
            map_pend <= xfer;
            bin_pend <= (state == TR_LAST);
            qry_pend <= (state == TS_ENC) && encoding_done;
            tsf_pend <= (state_nxt == DONE) && (state != DONE);
            if (go_acc) begin
                label_err  <= 1'b0;
                test_empty <= (cfg_test_samples == '0);
            end
            if (xfer) begin
                class_select_bits <= sample_label;
                cur_bad           <= label_invalid(sample_label);
                if (label_invalid(sample_label))
                    label_err <= 1'b1;
            end
        end
    end

`ifdef HDC_SEQ_ACC_COUNT_EN
    logic [CNT_W-1:0] correct_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            correct_q <= '0;
        else if (en) begin
            if (go_acc)
                correct_q <= '0;
            else if ((state == TS_QUERY) && query_done &&
                     (class_inference == class_select_bits) && (correct_q != '1))
                correct_q <= correct_q + CNT_W'(1);
        end
    end

    assign correct_count = correct_q;
`else
    logic unused_inference;
    assign unused_inference = ^class_inference;
    assign correct_count    = '0;
`endif

    assign sample_ready = en && ((state == TR_FETCH) || (state == TS_FETCH));

    assign start_mapping             = en && map_pend;
    assign acc_strobe                = en && (state == TR_ACC) && !cur_bad;
    assign training_dataset_finished = en && (state == TR_LAST);
    assign start_binarizing          = en && bin_pend;
    assign start_querying            = en && qry_pend;
    assign testing_dataset_finished  = en && tsf_pend;

    assign train_mode = (state == TR_FETCH) || (state == TR_ENC) || (state == TR_ACC) ||
                        (state == TR_LAST)  || (state == BIN_WAIT);
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_hdc_dataset_sequencer.sv
module tb_hdc_dataset_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        go;
    logic [15:0] cfg_train_samples;
    logic [15:0] cfg_test_samples;
    logic        sample_valid;
    logic [4:0]  sample_label;
    logic        sample_ready;
    logic        start_mapping;
    logic        encoding_done;
    logic        train_mode;
    logic        acc_strobe;
    logic [4:0]  class_select_bits;
    logic        training_dataset_finished;
    logic        start_binarizing;
    logic        class_gen_done;
    logic        start_querying;
    logic        query_done;
    logic [4:0]  class_inference;
    logic        testing_dataset_finished;
    logic [15:0] correct_count;
    logic        label_err;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    int n_acc  = 0;
    int n_sq   = 0;
    int base_xfer, base_acc, base_sq;

`ifdef HDC_SEQ_ACC_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    hdc_dataset_sequencer dut (
        .clk                       (clk),
        .rst                       (rst),
        .en                        (en),
        .go                        (go),
        .cfg_train_samples         (cfg_train_samples),
        .cfg_test_samples          (cfg_test_samples),
        .sample_valid              (sample_valid),
        .sample_label              (sample_label),
        .sample_ready              (sample_ready),
        .start_mapping             (start_mapping),
        .encoding_done             (encoding_done),
        .train_mode                (train_mode),
        .acc_strobe                (acc_strobe),
        .class_select_bits         (class_select_bits),
        .training_dataset_finished (training_dataset_finished),
        .start_binarizing          (start_binarizing),
        .class_gen_done            (class_gen_done),
        .start_querying            (start_querying),
        .query_done                (query_done),
        .class_inference           (class_inference),
        .testing_dataset_finished  (testing_dataset_finished),
        .correct_count             (correct_count),
        .label_err                 (label_err),
        .busy                      (busy),
        .done                      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample_valid && sample_ready) n_xfer++;
        if (acc_strobe)                   n_acc++;
        if (start_querying)               n_sq++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] ntr, input logic [15:0] nts);
        cfg_train_samples = ntr;
        cfg_test_samples  = nts;
        go = 1'b1;
        step(1);
        go = 1'b0;
    endtask

    // Offer one training sample with immediate valid and a one-cycle encoder.
    task automatic train_sample(input logic [4:0] lab);
        sample_valid = 1'b1;
        sample_label = lab;
        step(1);
        sample_valid = 1'b0;
        sample_label = 5'd0;
        chk("tr_map_pulse", start_mapping, 1);
        chk("tr_class_sel", class_select_bits, lab);
        encoding_done = 1'b1;
        step(1);
        encoding_done = 1'b0;
        chk("tr_acc", acc_strobe, (lab < 5'd26) ? 1 : 0);
        step(1);
    endtask

    // From TR_LAST: check the two boundary strobes, then finish binarization.
    task automatic finish_training();
        chk("tdf_pulse", training_dataset_finished, 1);
        chk("sb_early", start_binarizing, 0);
        step(1);
        chk("sb_pulse", start_binarizing, 1);
        chk("tdf_width", training_dataset_finished, 0);
        chk("bin_train_mode", train_mode, 1);
        step(1);
        chk("sb_width", start_binarizing, 0);
        class_gen_done = 1'b1;
        step(1);
        class_gen_done = 1'b0;
    endtask

    task automatic test_sample(input logic [4:0] lab, input logic [4:0] inf, input bit last);
        sample_valid = 1'b1;
        sample_label = lab;
        step(1);
        sample_valid = 1'b0;
        chk("ts_map_pulse", start_mapping, 1);
        encoding_done = 1'b1;
        step(1);
        encoding_done = 1'b0;
        chk("sq_pulse", start_querying, 1);
        step(1);
        chk("sq_width", start_querying, 0);
        query_done      = 1'b1;
        class_inference = inf;
        step(1);
        query_done = 1'b0;
        if (last) begin
            chk("tsf_pulse", testing_dataset_finished, 1);
            chk("done_level", done, 1);
            chk("busy_at_done", busy, 0);
        end else begin
            chk("ts_next_ready", sample_ready, 1);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; go = 1'b0;
        cfg_train_samples = '0; cfg_test_samples = '0;
        sample_valid = 1'b0; sample_label = '0;
        encoding_done = 1'b0; class_gen_done = 1'b0;
        query_done = 1'b0; class_inference = '0;
        step(2);
        chk("rst_ready", sample_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_train_mode", train_mode, 0);
        chk("rst_csb", class_select_bits, 0);
        chk("rst_correct", correct_count, 0);
        chk("rst_label_err", label_err, 0);
        rst = 1'b0;
        step(1);
        chk("idle_busy", busy, 0);

        // Train 3 / test 2, all inferences correct
        base_acc = n_acc; base_sq = n_sq;
        start_run(16'd3, 16'd2);
        chk("t1_ready", sample_ready, 1);
        chk("t1_busy", busy, 1);
        chk("t1_train_mode", train_mode, 1);
        train_sample(5'd3);
        train_sample(5'd7);
        train_sample(5'd25);
        finish_training();
        chk("t1_ts_train_mode", train_mode, 0);
        chk("t1_ts_ready", sample_ready, 1);
        test_sample(5'd3, 5'd3, 1'b0);
        test_sample(5'd7, 5'd7, 1'b1);
        step(1);
        chk("t1_tsf_width", testing_dataset_finished, 0);
        chk("t1_correct", correct_count, CNT_ON ? 2 : 0);
        chk("t1_acc_count", n_acc - base_acc, 3);
        chk("t1_sq_count", n_sq - base_sq, 2);

        // Train 0 / test 0 with sample_valid held high
        base_xfer = n_xfer;
        sample_valid = 1'b1;
        start_run(16'd0, 16'd0);
        chk("t2_correct_cleared", correct_count, 0);
        chk("t2_ready", sample_ready, 0);
        chk("t2_tdf", training_dataset_finished, 1);
        step(1);
        chk("t2_sb", start_binarizing, 1);
        step(3);
        chk("t2_wait_busy", busy, 1);
        chk("t2_wait_done", done, 0);
        chk("t2_wait_ready", sample_ready, 0);
        class_gen_done = 1'b1;
        step(1);
        class_gen_done = 1'b0;
        chk("t2_tsf", testing_dataset_finished, 1);
        chk("t2_done", done, 1);
        sample_valid = 1'b0;
        chk("t2_no_xfer", n_xfer - base_xfer, 0);

        // Out-of-range label during training
        base_acc = n_acc;
        start_run(16'd3, 16'd0);
        train_sample(5'd1);
        chk("t4_err_before", label_err, 0);
        train_sample(5'd30);
        chk("t4_err_set", label_err, 1);
        train_sample(5'd2);
        finish_training();
        chk("t4_tsf", testing_dataset_finished, 1);
        chk("t4_done", done, 1);
        chk("t4_err_sticky", label_err, 1);
        chk("t4_acc_count", n_acc - base_acc, 2);

        // Test 4 with match/mismatch/match/mismatch; go clears label_err
        start_run(16'd1, 16'd4);
        chk("t3_err_cleared", label_err, 0);
        train_sample(5'd5);
        finish_training();
        test_sample(5'd4, 5'd4, 1'b0);
        test_sample(5'd6, 5'd7, 1'b0);
        test_sample(5'd9, 5'd9, 1'b0);
        test_sample(5'd0, 5'd1, 1'b1);
        chk("t3_correct", correct_count, CNT_ON ? 2 : 0);

        // Reset while in TS_QUERY, then a clean run
        start_run(16'd1, 16'd1);
        train_sample(5'd2);
        finish_training();
        sample_valid = 1'b1; sample_label = 5'd4;
        step(1);
        sample_valid = 1'b0;
        encoding_done = 1'b1;
        step(1);
        encoding_done = 1'b0;
        chk("t5_in_query", start_querying, 1);
        rst = 1'b1;
        step(1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_sq", start_querying, 0);
        chk("t5_rst_train_mode", train_mode, 0);
        chk("t5_rst_csb", class_select_bits, 0);
        chk("t5_rst_correct", correct_count, 0);
        rst = 1'b0;
        step(1);
        start_run(16'd2, 16'd1);
        train_sample(5'd1);
        train_sample(5'd2);
        finish_training();
        test_sample(5'd2, 5'd2, 1'b1);
        chk("t5_correct", correct_count, CNT_ON ? 1 : 0);

        // en low for 5 cycles in TR_ENC while sample_valid toggles
        base_xfer = n_xfer; base_acc = n_acc;
        start_run(16'd1, 16'd0);
        sample_valid = 1'b1; sample_label = 5'd8;
        step(1);
        sample_valid = 1'b0;
        chk("t6_map", start_mapping, 1);
        step(1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_valid  = (i % 2 == 0);
            encoding_done = (i == 2);
            #1;
            chk("t6_frz_ready", sample_ready, 0);
            chk("t6_frz_acc", acc_strobe, 0);
            chk("t6_frz_busy", busy, 1);
            step(1);
        end
        en = 1'b1; sample_valid = 1'b0; encoding_done = 1'b0;
        step(1);
        chk("t6_enc_lost", acc_strobe, 0);
        chk("t6_still_train", train_mode, 1);
        encoding_done = 1'b1;
        step(1);
        encoding_done = 1'b0;
        chk("t6_acc", acc_strobe, 1);
        step(1);
        finish_training();
        chk("t6_done", done, 1);
        chk("t6_xfer_count", n_xfer - base_xfer, 1);
        chk("t6_acc_count", n_acc - base_acc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
